fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin, packet-locking write arbiter that shares one 36-bit sync FIFO (512 deep) write port among NUM_REQ producers, e.g. ray generators or shader units. A grant is held for a whole multi-word packet, delimited by a last flag, so packets from different requesters never interleave in the FIFO. Sits directly in front of the FIFO's wr_data/wr_en/full interface. Same clock domain as the FIFO.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
DATA_W, 36, word width; must match the FIFO word width.
ID_W, 2, grant index width; must be >= ceil(log2(NUM_REQ)).
CNT_W, 16, width of the completed-packet counter.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester word valid
req_last  in  NUM_REQ  per-requester: current word is the final word of its packet
req_data  in  NUM_REQ*DATA_W  requester i's word occupies bits [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  per-requester accept; a transfer happens when valid & ready are both high
fifo_wr_data  out  DATA_W  to FIFO wr_data
fifo_wr_en  out  1  to FIFO wr_en
fifo_full  in  1  from FIFO full
grant_id  out  ID_W  index of current or candidate owner
locked  out  1  high while a multi-word packet is in progress
pkt_count  out  CNT_W  completed packets, wraps modulo 2^CNT_W

Behaviour:
- Registered state: fsm {IDLE, LOCKED}, rr_ptr (ID_W), owner (ID_W), pkt_count.
- Reset (async, rst high): fsm=IDLE, rr_ptr=0, owner=0, pkt_count=0. While rst is high, req_ready=0, fifo_wr_en=0, locked=0 and grant_id=0, regardless of inputs.
- Data path is combinational, with zero added latency. fifo_wr_data = data of the selected requester. fifo_wr_en = selected valid & !fifo_full. req_ready[sel] = !fifo_full; all other ready bits are 0.
- IDLE selection: sel = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... and wrapping mod NUM_REQ. If no requester is valid: sel=rr_ptr, fifo_wr_en=0, all ready bits 0.
- IDLE, transfer with req_last[sel]=1 (single-word packet): stay in IDLE; rr_ptr <= (sel+1) mod NUM_REQ; pkt_count++.
- IDLE, transfer with req_last[sel]=0: go to LOCKED; owner <= sel. rr_ptr is unchanged.
- IDLE with fifo_full=1: no transfer and no state change. The candidate may change next cycle if the valids change; nothing is committed.
- LOCKED: sel=owner only; other requesters' ready bits are 0 even if they are valid. On an owner transfer with last=1: go to IDLE, rr_ptr <= (owner+1) mod NUM_REQ, pkt_count++. On a transfer with last=0, stay in LOCKED.
- LOCKED with owner valid=0 (a bubble) or fifo_full=1: hold LOCKED with no timeout; the grant is never revoked mid-packet.
- grant_id = sel. locked = (fsm==LOCKED).
- Requesters must hold data/last stable while valid is high and ready is low. The arbiter does not check this.
- fifo_full is sampled combinationally. The block never asserts fifo_wr_en while fifo_full=1, so the FIFO's internal full guard is never exercised.
- Reset mid-packet: the arbiter returns to IDLE immediately. Any partial packet already written to the FIFO is not cleaned up; FIFO and producers are reset together with the arbiter.
- pkt_count wraps from 2^CNT_W-1 to 0 without saturating.

Test Plan:
- Single-word packets from all four requesters held valid with last=1 and the FIFO never full -> grants 0,1,2,3,0,... one per cycle; after 8 cycles pkt_count=8 and the FIFO holds the words in that order.
- Requester 1 sends a 3-word packet (A1,B1,C1, last on C1) while requester 2 is continuously valid -> ready[2]=0 for the 3 cycles; FIFO order A1,B1,C1, then req2's word; rr_ptr=2 after C1.
- Locked owner 0 drops valid for 2 cycles mid-packet while requester 3 is valid -> locked stays 1, fifo_wr_en=0 during the gap, and req3 is not served until owner 0 sends last.
- fifo_full forced to 1 for 5 cycles while requests are pending -> fifo_wr_en=0, all ready bits 0, pkt_count unchanged; after full deasserts, arbitration resumes from the unchanged rr_ptr.
- rst pulsed while LOCKED with owner=2 after 1 of 4 words -> on the same edge, locked=0, all ready bits 0, pkt_count=0; after release, requester 0 wins first when all are valid.
- Preload pkt_count near wrap (CNT_W=4, 16 single-word packets) -> pkt_count reads 0 after the 16th.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a single FIFO write port.
// A grant is held until the owner's last word, so packets never interleave.
module fifo_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 36,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         fifo_wr_data,
  output logic                      fifo_wr_en,
  input  logic                      fifo_full,
  output logic [ID_W-1:0]           grant_id,
  output logic                      locked,
  output logic [CNT_W-1:0]          pkt_count
);

  // state  | meaning
  // IDLE   | no packet in progress; round-robin search from rr_ptr
  // LOCKED | owner is mid-packet; only owner may write until its last word
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          fsm;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] owner;
  logic [ID_W-1:0] sel;
  logic [ID_W-1:0] sel_next;
  logic            any_valid;
  logic            sel_valid;
  logic            sel_last;
  logic            xfer;

  always_comb begin
    int idx;
    idx       = 0;
    sel       = rr_ptr;
    any_valid = 1'b0;
    if (fsm == LOCKED) begin
      sel = owner;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!any_valid && req_valid[idx]) begin
          sel       = ID_W'(idx);
          any_valid = 1'b1;
        end
      end
    end
  end

  assign sel_valid    = req_valid[sel];
  assign sel_last     = req_last[sel];
  assign sel_next     = (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + ID_W'(1);
  assign xfer         = !rst && sel_valid && !fifo_full;
  assign fifo_wr_en   = xfer;
  assign fifo_wr_data = req_data[int'(sel)*DATA_W +: DATA_W];
  assign grant_id     = rst ? '0 : sel;
  assign locked       = !rst && (fsm == LOCKED);

  // While locked the owner sees ready even during a bubble, so it can resume at once.
  always_comb begin
    req_ready = '0;
    if (!rst && !fifo_full && ((fsm == LOCKED) || any_valid))
      req_ready[sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      pkt_count <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (xfer) begin
            if (sel_last) begin
              rr_ptr    <= sel_next;
              pkt_count <= pkt_count + CNT_W'(1);
            end else begin
              fsm   <= LOCKED;
              owner <= sel;
            end
          end
        end
        LOCKED: begin
          if (xfer && sel_last) begin
            fsm       <= IDLE;
            rr_ptr    <= sel_next;
            pkt_count <= pkt_count + CNT_W'(1);
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed, table-driven bench for fifo_wr_arbiter (4 requesters, 4-bit packet counter).
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 36;
  localparam int IW = 2;
  localparam int CW = 4;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_last;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic [DW-1:0]    fifo_wr_data;
  logic             fifo_wr_en;
  logic             fifo_full;
  logic [IW-1:0]    grant_id;
  logic             locked;
  logic [CW-1:0]    pkt_count;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ID_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready),
    .fifo_wr_data(fifo_wr_data), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
    .grant_id(grant_id), .locked(locked), .pkt_count(pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] v;
    logic [3:0] l;
    logic       full;
    logic [1:0] g;
    logic [3:0] rdy;
    logic       we;
    logic       lk;
    logic [3:0] cnt;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];
  int            errors = 0;
  int            checks = 0;
  int            tag    = 0;

  always @(posedge clk)
    if (!rst && fifo_wr_en) got_q.push_back(fifo_wr_data);

  function automatic logic [DW-1:0] word(input int i, input int t);
    logic [DW-1:0] w;
    w        = '0;
    w[35:32] = 4'(i);
    w[15:0]  = 16'(t);
    return w;
  endfunction

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic full,
                              input logic [1:0] g, input logic [3:0] rdy, input logic we,
                              input logic lk, input logic [3:0] cnt);
    vec_t t;
    t.v = v; t.l = l; t.full = full; t.g = g; t.rdy = rdy; t.we = we; t.lk = lk; t.cnt = cnt;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic full);
    req_valid = v;
    req_last  = l;
    fifo_full = full;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = word(i, tag);
  endtask

  task automatic apply(input vec_t t, input int n);
    @(negedge clk);
    tag++;
    drive(t.v, t.l, t.full);
    #1;
    chk($sformatf("v%0d grant", n), grant_id, t.g);
    chk($sformatf("v%0d ready", n), req_ready, t.rdy);
    chk($sformatf("v%0d wr_en", n), fifo_wr_en, t.we);
    chk($sformatf("v%0d locked", n), locked, t.lk);
    chk($sformatf("v%0d pkt_count", n), pkt_count, t.cnt);
    if (t.we) begin
      chk($sformatf("v%0d wr_data", n), fifo_wr_data, word(t.g, tag));
      exp_q.push_back(word(t.g, tag));
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(4'hF, 4'hF, 1'b0);

    // 1: single-word packets from all requesters, strict rotation
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(4'hF, 4'hF, 1'b0, 2'(k % 4), 4'(1 << (k % 4)), 1'b1, 1'b0, 4'(k)));
    vecs.push_back(mk(4'h0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 4'd8));
    // 2: req1 3-word packet while req2 waits
    vecs.push_back(mk(4'b0110, 4'b0000, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0, 4'd8));
    vecs.push_back(mk(4'b0110, 4'b0000, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b1, 4'd8));
    vecs.push_back(mk(4'b0110, 4'b0010, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b1, 4'd8));
    vecs.push_back(mk(4'b0100, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0, 4'd9));
    // 3: owner 0 bubbles for two cycles while req3 waits
    vecs.push_back(mk(4'b0001, 4'b0000, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0, 4'd10));
    vecs.push_back(mk(4'b1000, 4'b0000, 1'b0, 2'd0, 4'b0001, 1'b0, 1'b1, 4'd10));
    vecs.push_back(mk(4'b1000, 4'b0000, 1'b0, 2'd0, 4'b0001, 1'b0, 1'b1, 4'd10));
    vecs.push_back(mk(4'b1001, 4'b0001, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b1, 4'd10));
    vecs.push_back(mk(4'b1000, 4'b1000, 1'b0, 2'd3, 4'b1000, 1'b1, 1'b0, 4'd11));
    // 4: FIFO full for 5 cycles, then resume from rr_ptr=0
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(4'b0110, 4'b0110, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0, 4'd12));
    vecs.push_back(mk(4'b0110, 4'b0110, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0, 4'd12));
    vecs.push_back(mk(4'b0110, 4'b0110, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0, 4'd13));
    // 5: full while locked, then finish; then counter wrap on the 16th packet
    vecs.push_back(mk(4'b0001, 4'b0000, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0, 4'd14));
    vecs.push_back(mk(4'b0001, 4'b0000, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b1, 4'd14));
    vecs.push_back(mk(4'b0001, 4'b0001, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b1, 4'd14));
    vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 2'd1, 4'b0000, 1'b0, 1'b0, 4'd15));
    vecs.push_back(mk(4'b0100, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0, 4'd15));
    vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 2'd3, 4'b0000, 1'b0, 1'b0, 4'd0));
    // 6: one packet from req2, then lock req2 after its first word
    vecs.push_back(mk(4'b0100, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0, 4'd0));
    vecs.push_back(mk(4'b0100, 4'b0000, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0, 4'd1));
    vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 2'd2, 4'b0100, 1'b0, 1'b1, 4'd1));

    // reset holds all outputs inactive regardless of inputs
    @(negedge clk); #1;
    chk("rst grant", grant_id, 2'd0);
    chk("rst ready", req_ready, 4'h0);
    chk("rst wr_en", fifo_wr_en, 1'b0);
    chk("rst locked", locked, 1'b0);
    chk("rst pkt_count", pkt_count, 4'd0);
    @(negedge clk);
    drive(4'h0, 4'h0, 1'b0);
    rst = 1'b0;

    for (int n = 0; n < vecs.size(); n++) apply(vecs[n], n);

    // reset mid-packet with owner 2 locked
    @(posedge clk); #2;
    drive(4'hF, 4'hF, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst locked", locked, 1'b0);
    chk("midrst ready", req_ready, 4'h0);
    chk("midrst wr_en", fifo_wr_en, 1'b0);
    chk("midrst grant", grant_id, 2'd0);
    chk("midrst pkt_count", pkt_count, 4'd0);
    @(negedge clk);
    drive(4'h0, 4'h0, 1'b0);
    rst = 1'b0;
    apply(mk(4'hF, 4'hF, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0, 4'd0), 100);
    apply(mk(4'hF, 4'hF, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0, 4'd1), 101);
    apply(mk(4'h0, 4'h0, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0, 4'd2), 102);

    // FIFO contents in write order
    chk("fifo length", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("fifo word %0d", i), got_q[i], exp_q[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
